level_slew: RTL and testbench

- Slew-rate limiter between the quadrature encoder count and the PWM generator in the RGB mixer channel.
- Takes the raw encoder value as a target and moves an internal level toward it by at most STEP every PRESCALE clocks.
- Encoder jumps therefore produce smooth brightness ramps.
- Its output drives the PWM level input directly.

---
 rtl/level_slew.sv | 139 +++++++++++++
 tb/tb_level_slew.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/level_slew.sv
// rtl/level_slew.sv - slew-rate limiter from encoder target to PWM level
// Optional: define LEVEL_SLEW_GAMMA_EN for a registered square-law gamma on level.
module level_slew #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1000,
  parameter int STEP     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] level,
  output logic             settled,
  output logic             ramping
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  localparam logic [15:0]      COUNT_MAX = 16'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] STEP_N    = WIDTH'(STEP);

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      count;
  logic             tick;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] cur_nxt;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_amt;
  logic             settled_q;
  logic             ramping_raw;

  // A tick only exists while enabled; disabled cycles never reach COUNT_MAX
  // because the counter is parked at zero.
  assign tick = enable && (count == COUNT_MAX);

  // Prescaler: counts enabled cycles, parks at zero whenever disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

  // Next state from the live target so a mid-ramp reversal takes effect at the
  // very next tick without ever stepping in the stale direction.
  always_comb begin
    state_nxt = state;
    if (enable) begin
      if (target > cur) begin
        state_nxt = UP;
      end else if (target < cur) begin
        state_nxt = DOWN;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // Step size clipped to the remaining distance, so cur cannot overshoot or wrap.
  always_comb begin
    diff     = '0;
    step_amt = '0;
    cur_nxt  = cur;
    if (target >= cur) begin
      diff = {1'b0, target} - {1'b0, cur};
    end else begin
      diff = {1'b0, cur} - {1'b0, target};
    end
    if ({1'b0, STEP_N} < diff) begin
      step_amt = STEP_N;
    end else begin
      step_amt = diff[WIDTH-1:0];
    end
    if (tick) begin
      case (state_nxt)
        UP:      cur_nxt = cur + step_amt;
        DOWN:    cur_nxt = cur - step_amt;
        default: cur_nxt = cur;
      endcase
    end
  end

  // State register, current level and the settled flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cur       <= '0;
      settled_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur       <= cur_nxt;
      settled_q <= enable && (cur == target);
    end
  end

  assign ramping_raw = (state != IDLE);

`ifdef LEVEL_SLEW_GAMMA_EN
  logic [2*WIDTH-1:0] sq;
  logic [WIDTH-1:0]   sq_hi;
  logic [WIDTH-1:0]   sq_lo_unused;
  logic [WIDTH-1:0]   level_q;
  logic               settled_d;
  logic               ramping_d;

  assign sq                   = {{WIDTH{1'b0}}, cur} * {{WIDTH{1'b0}}, cur};
  assign {sq_hi, sq_lo_unused} = sq;

  // Gamma stage; flags take the same extra register so they line up with level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q   <= '0;
      settled_d <= 1'b0;
      ramping_d <= 1'b0;
    end else begin
      level_q   <= sq_hi;
      settled_d <= settled_q;
      ramping_d <= ramping_raw;
    end
  end

  assign level   = level_q;
  assign settled = settled_d;
  assign ramping = ramping_d;
`else
  assign level   = cur;
  assign settled = settled_q;
  assign ramping = ramping_raw;
`endif

endmodule

// File: tb/tb_level_slew.sv
// tb/tb_level_slew.sv - randomized self-checking bench for level_slew against a behavioural model
module tb_level_slew;

  localparam int PS = 4;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [7:0]       target;
  logic [2:0][7:0]  lvl;
  logic [2:0]       set_o;
  logic [2:0]       ramp_o;

  int n_tests = 0;
  int n_fail  = 0;

  int st[3] = '{1, 16, 255};
  int m_cur[3], m_run[3], m_set[3], m_ramp[3];
  int g_lvl[3], g_set[3], g_ramp[3];

  level_slew #(.WIDTH(8), .PRESCALE(PS), .STEP(1)) u_s1 (
    .clk(clk), .reset(reset), .enable(enable), .target(target),
    .level(lvl[0]), .settled(set_o[0]), .ramping(ramp_o[0]));
  level_slew #(.WIDTH(8), .PRESCALE(PS), .STEP(16)) u_s16 (
    .clk(clk), .reset(reset), .enable(enable), .target(target),
    .level(lvl[1]), .settled(set_o[1]), .ramping(ramp_o[1]));
  level_slew #(.WIDTH(8), .PRESCALE(PS), .STEP(255)) u_s255 (
    .clk(clk), .reset(reset), .enable(enable), .target(target),
    .level(lvl[2]), .settled(set_o[2]), .ramping(ramp_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_cur[i] = 0; m_run[i] = 0; m_set[i] = 0; m_ramp[i] = 0;
      g_lvl[i] = 0; g_set[i] = 0; g_ramp[i] = 0;
    end
  endtask

  // One clock edge of the reference: a tick every PS-th consecutive enabled cycle,
  // level moves toward target by at most STEP.
  task automatic model_edge();
    int d, mag;
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        m_cur[i] = 0; m_run[i] = 0; m_set[i] = 0; m_ramp[i] = 0;
        g_lvl[i] = 0; g_set[i] = 0; g_ramp[i] = 0;
      end else begin
        g_lvl[i]  = (m_cur[i] * m_cur[i]) / 256;
        g_set[i]  = m_set[i];
        g_ramp[i] = m_ramp[i];
        m_set[i]  = (enable && (m_cur[i] == int'(target))) ? 1 : 0;
        if (enable) begin
          m_ramp[i] = (int'(target) != m_cur[i]) ? 1 : 0;
          m_run[i]++;
          if (m_run[i] % PS == 0) begin
            d   = int'(target) - m_cur[i];
            mag = (d < 0) ? -d : d;
            if (mag > st[i]) mag = st[i];
            m_cur[i] = m_cur[i] + ((d > 0) ? mag : -mag);
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
`ifdef LEVEL_SLEW_GAMMA_EN
      check($sformatf("level[%0d]", i), int'(lvl[i]), g_lvl[i]);
      check($sformatf("settled[%0d]", i), int'(set_o[i]), g_set[i]);
      check($sformatf("ramping[%0d]", i), int'(ramp_o[i]), g_ramp[i]);
`else
      check($sformatf("level[%0d]", i), int'(lvl[i]), m_cur[i]);
      check($sformatf("settled[%0d]", i), int'(set_o[i]), m_set[i]);
      check($sformatf("ramping[%0d]", i), int'(ramp_o[i]), m_ramp[i]);
`endif
    end
  endtask

  // Inputs change at the negedge; the DUT sees them at the next posedge.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic sync_reset();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  task automatic wait_level(input string tag, input int idx, input int val, input int budget);
    int hit;
    hit = 0;
    for (int k = 0; k < budget && hit == 0; k++) begin
      cycle();
      if (int'(lvl[idx]) == val) hit = 1;
    end
    check(tag, hit, 1);
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    target = 8'd200;
    model_clear();
    @(negedge clk);

    // Held in reset with a non-zero target.
    cycles(3);
    check("rst_level", int'(lvl[0]), 0);
    check("rst_settled", int'(set_o[0]), 0);
    check("rst_ramping", int'(ramp_o[0]), 0);

    // Release and ramp 0 -> 200 with STEP=1.
    reset = 1'b1;
    cycles(3);
`ifndef LEVEL_SLEW_GAMMA_EN
    check("pre_first_tick", int'(lvl[0]), 0);
`endif
    cycle();
`ifndef LEVEL_SLEW_GAMMA_EN
    check("first_tick", int'(lvl[0]), 1);
`endif
    cycles(796);
`ifndef LEVEL_SLEW_GAMMA_EN
    check("reach_200", int'(lvl[0]), 200);
    check("settled_lag", int'(set_o[0]), 0);
`endif
    cycle();
`ifndef LEVEL_SLEW_GAMMA_EN
    check("settled_200", int'(set_o[0]), 1);
    check("idle_200", int'(ramp_o[0]), 0);
`endif

    // Overshoot guard on the STEP=16 instance.
    target = 8'd40;
    sync_reset();
    cycles(4);
`ifndef LEVEL_SLEW_GAMMA_EN
    check("s16_t1", int'(lvl[1]), 16);
`endif
    cycles(4);
`ifndef LEVEL_SLEW_GAMMA_EN
    check("s16_t2", int'(lvl[1]), 32);
`endif
    cycles(4);
`ifndef LEVEL_SLEW_GAMMA_EN
    check("s16_t3_clip", int'(lvl[1]), 40);
`endif
    cycles(8);
`ifndef LEVEL_SLEW_GAMMA_EN
    check("s16_hold", int'(lvl[1]), 40);
`endif

    // Direction reversal at 100 while heading for 200.
    target = 8'd200;
    sync_reset();
    cycles(400);
`ifndef LEVEL_SLEW_GAMMA_EN
    check("rev_at_100", int'(lvl[0]), 100);
`endif
    target = 8'd50;
    cycles(3);
`ifndef LEVEL_SLEW_GAMMA_EN
    check("rev_hold", int'(lvl[0]), 100);
`endif
    cycle();
`ifndef LEVEL_SLEW_GAMMA_EN
    check("rev_99", int'(lvl[0]), 99);
`endif
    cycles(196);
`ifndef LEVEL_SLEW_GAMMA_EN
    check("rev_reach_50", int'(lvl[0]), 50);
    check("rev_settled_lag", int'(set_o[0]), 0);
`endif
    cycle();
`ifndef LEVEL_SLEW_GAMMA_EN
    check("rev_settled", int'(set_o[0]), 1);
`endif

    // Enable gating at 60.
    target = 8'd200;
    wait_level("wait_60", 0, 60, 200);
    enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      check("gate_level", int'(lvl[0]), 60);
      check("gate_settled", int'(set_o[0]), 0);
    end
    enable = 1'b1;
    cycles(3);
    check("resume_hold", int'(lvl[0]), 60);
    cycle();
`ifndef LEVEL_SLEW_GAMMA_EN
    check("resume_61", int'(lvl[0]), 61);
`endif

    // Asynchronous reset between edges at 120.
    wait_level("wait_120", 0, 120, 400);
    #2 reset = 1'b0;
    model_clear();
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async_level[%0d]", i), int'(lvl[i]), 0);
      check($sformatf("async_settled[%0d]", i), int'(set_o[i]), 0);
      check($sformatf("async_ramping[%0d]", i), int'(ramp_o[i]), 0);
    end
    #1 reset = 1'b1;
    cycles(3);
    check("post_async_hold", int'(lvl[0]), 0);
    cycle();
`ifndef LEVEL_SLEW_GAMMA_EN
    check("post_async_1", int'(lvl[0]), 1);
`endif

    // Full-scale step on the STEP=255 instance.
    target = 8'd255;
    sync_reset();
    cycles(4);
`ifdef LEVEL_SLEW_GAMMA_EN
    check("s255_pre_gamma", int'(lvl[2]), 0);
`else
    check("s255_full", int'(lvl[2]), 255);
`endif
    cycle();
`ifdef LEVEL_SLEW_GAMMA_EN
    check("s255_gamma_255", int'(lvl[2]), 254);
`endif
    target = 8'd128;
    cycles(5);
`ifdef LEVEL_SLEW_GAMMA_EN
    check("s255_gamma_128", int'(lvl[2]), 64);
`else
    check("s255_128", int'(lvl[2]), 128);
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 29) == 0) target = 8'($urandom_range(0, 255));
      if (enable && $urandom_range(0, 59) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
      if ($urandom_range(0, 599) == 0) sync_reset();
      else cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
